// File: rtl/la_vrrsel6_pkg.sv
// rtl/la_vrrsel6_pkg.sv - shared constants, state type and pointer helpers for la_vrrsel6
package la_vrrsel6_pkg;

  localparam int NREQ = 6;
  localparam int PTRW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Mod-6 increment; 6 and 7 never occur but fold to 0 to stay in range.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p >= 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [PTRW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [PTRW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | PTRW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/la_rrpick6.sv
// rtl/la_rrpick6.sv - combinational round-robin pick over six requesters
module la_rrpick6
  import la_vrrsel6_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [PTRW-1:0] idx
);

  logic            found;
  logic [PTRW-1:0] pos;

  // Scan ptr+1 .. ptr+6 (mod 6); the last granted requester is checked last.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    pos   = next_ptr(ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[pos]) begin
        found     = 1'b1;
        pick[pos] = 1'b1;
        idx       = pos;
      end
      pos = next_ptr(pos);
    end
  end

endmodule

// File: rtl/la_vrrsel6.sv
// rtl/la_vrrsel6.sv - 6-way round-robin arbiter with registered one-hot selects; LA_VRRSEL6_LOCK_EN adds lock
module la_vrrsel6
  import la_vrrsel6_pkg::*;
#(
  parameter                  PROP     = "DEFAULT",
  parameter logic [PTRW-1:0] RESETPTR = 3'd5
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic            valid,
  input  logic            ready,
  output logic            sel5,
  output logic            sel4,
  output logic            sel3,
  output logic            sel2,
  output logic            sel1,
  output logic            sel0,
  output logic [NREQ-1:0] ack
`ifdef LA_VRRSEL6_LOCK_EN
  ,
  input  logic            lock
`endif
);

  // PROP only steers cell selection in implementation flows.
  if (PROP != "DEFAULT") begin : g_prop
  end

  state_t          state, state_n;
  logic [NREQ-1:0] sel, sel_n;
  logic [PTRW-1:0] ptr, ptr_n;

  logic            accept;
  logic            hold;
  logic [PTRW-1:0] sel_idx;
  logic [NREQ-1:0] pick_req;
  logic [PTRW-1:0] pick_ptr;
  logic [NREQ-1:0] pick;
  logic [PTRW-1:0] pick_idx;

  assign accept  = (state == GRANT) && ready;
  assign sel_idx = onehot_idx(sel);

`ifdef LA_VRRSEL6_LOCK_EN
  assign hold = accept && lock;
`else
  assign hold = 1'b0;
`endif

  // On accept the grantee is masked and the scan starts after it, which is
  // the pointer value it is about to become.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr;
    if (state == GRANT) begin
      pick_req = req & ~sel;
      pick_ptr = sel_idx;
    end
  end

  la_rrpick6 u_pick (
    .req  (pick_req),
    .ptr  (pick_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_n   = pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (accept && !hold) begin
          ptr_n = sel_idx;
          if (|pick_req) begin
            sel_n = pick;
          end else begin
            sel_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        sel_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= RESETPTR;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
    end
  end

  // A reset edge discards the beat, so no ack is reported for it.
  assign ack   = (accept && !reset) ? sel : '0;
  assign valid = (state == GRANT);

  assign {sel5, sel4, sel3, sel2, sel1, sel0} = sel;

  logic unused_pick_idx;
  assign unused_pick_idx = ^pick_idx;

endmodule
